chacha_xor_stream: RTL and testbench
====================================

Name: chacha_xor_stream

Overview:
- Downstream consumer of the chacha keystream core.
- Waits for a finished 64-byte block (core `blk_ready`) and pulses the core's `rd_blk`. Captures the uninterruptible 64-cycle burst into a local buffer, then XORs the buffer byte-by-byte with a valid/ready plaintext stream.
- The buffer decouples the core's fixed-rate read burst from a stallable message interface. Draining the buffer lets the core auto-increment its counter and compute the next block.

Parameters:
- BLOCK_BYTES, 64, keystream bytes per block. Must equal the core's burst length; power of two.
- PTR_W, 6, log2(BLOCK_BYTES).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- ks_ready  input  1  core `blk_ready`; a block is available
- ks_rd  output  1  core `rd_blk`; single-cycle pulse starting a burst
- ks_data  input  8  core `data_out`; burst byte i is valid in cycle i after `ks_rd` (byte 0 in the same cycle)
- in_valid  input  1  plaintext byte valid
- in_ready  output  1  plaintext byte accepted this cycle if `in_valid` is high
- in_data  input  8  plaintext byte
- out_valid  output  1  ciphertext byte valid
- out_ready  input  1  downstream accepts the ciphertext byte
- out_data  output  8  ciphertext byte
- flush  input  1  discard the rest of the current keystream block
- blk_count  output  16  keystream blocks fully captured since reset; wraps

Behaviour:
- Reset (synchronous, `rst_n` low): state=WAIT.
  - `ks_rd`=0, `in_ready`=0, `out_valid`=0, `out_data`=0.
  - `blk_count`=0, `wr_ptr`=0, `rd_ptr`=0.
  - Buffer contents are don't-care.
- WAIT:
  - If `ks_ready`=1 and `flush`=0: assert `ks_rd` for exactly this cycle, write `ks_data` into buf[0], set `wr_ptr`=1, go to FILL.
  - `ks_rd` is never asserted outside WAIT.
- FILL:
  - Each cycle write `ks_data` into buf[`wr_ptr`] and increment `wr_ptr`. No stall is possible.
  - When `wr_ptr`=BLOCK_BYTES-1 is written: `wr_ptr` wraps to 0, `blk_count`++, `rd_ptr`=0, go to SERVE.
  - If `flush` was seen at any point during FILL, go to WAIT instead of SERVE. `blk_count` still increments.
- SERVE:
  - `in_ready` = 1 when `out_valid`=0 or `out_ready`=1 (purely combinational; 0 in all other states).
  - Accept occurs when `in_valid` and `in_ready` are both high:
    - `out_data` <= `in_data` XOR buf[`rd_ptr`], `out_valid` <= 1, `rd_ptr`++.
    - Latency: 1 cycle from accept to `out_valid`.
  - When the accepted byte is at `rd_ptr`=BLOCK_BYTES-1: `rd_ptr` wraps to 0, go to WAIT.
  - `flush`=1 in SERVE: go to WAIT next cycle with `rd_ptr`=0. No accept in that cycle (`in_ready` is forced to 0 when `flush`=1).
- Output register:
  - `out_valid` clears on (`out_valid` & `out_ready` & no new accept).
  - `out_data` and `out_valid` are held stable while `out_ready`=0.
  - A pending output byte survives `flush` and the transition to WAIT. It is never dropped except by reset.
- Throughput: 1 byte/cycle in SERVE with `out_ready` held high. A block boundary costs 1 (WAIT) + 63 (FILL) cycles, plus the core's compute time.
- `blk_count` wraps 0xFFFF -> 0.
- Reset mid-FILL abandons the burst. The core shares `rst_n` and also returns to its clear state.
- No keystream byte is reused: each buf entry is XORed at most once per fill.

Decomposition:
- Shared package: state encoding (WAIT, FILL, SERVE), BLOCK_BYTES=64 constant used by both the core and this block.
- One natural sub-module: `ks_buffer`, a BLOCK_BYTES x 8 register array with a synchronous write port (`wr_en`, `wr_ptr`, `wr_data`) and an asynchronous read port (`rd_ptr`). All control stays in `chacha_xor_stream`.

Test Plan:
- Basic block: core model presents `ks_ready`, burst byte i = 0xA0+i. Feed 64 plaintext bytes 0x00..0x3F with `out_ready`=1.
  -> exactly one `ks_rd` pulse; `out_data`[i] = (0xA0+i)^i; `blk_count`=1; returns to WAIT.
- Burst alignment: `ks_rd` asserted in cycle T -> buf[0] = `ks_data`@T and buf[63] = `ks_data`@T+63. Check first ciphertext = 0xA0^`in_data`, not 0xA1^`in_data`.
- Backpressure: hold `out_ready`=0 for 5 cycles after the first accept.
  -> `in_ready`=0 during the stall; `out_data` stays (0xA0^0x00); no `rd_ptr` advance. After release, ciphertext continues with index 1.
- Two blocks: feed 100 bytes, second block pattern 0xC0+i.
  -> bytes 64..99 = (0xC0+(i-64))^`in_data`; `ks_rd` pulses twice; `blk_count`=2.
- Flush: `flush` after 10 bytes consumed, then 10 more bytes.
  -> new `ks_rd` pulse; byte 10 is XORed with the new block's byte 0. Flush asserted during FILL -> block discarded, another `ks_rd` issued, `blk_count` +2 total.
- Reset mid-FILL at burst cycle 20 -> all outputs reach reset values the next cycle; `ks_rd` re-pulses only after `ks_ready` is high again.

Source files
------------

// File: rtl/chacha_xor_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chacha_xor_stream_pkg
// Brief    : Shared constants for the keystream core and its XOR consumer.
// Revision : 1.0
// ============================================================================
package chacha_xor_stream_pkg;

  typedef logic [7:0] byte_t;

  localparam int c_block_bytes = 64;
  localparam int c_ptr_w       = $clog2(c_block_bytes);

  localparam logic [1:0] c_st_wait  = 2'd0;
  localparam logic [1:0] c_st_fill  = 2'd1;
  localparam logic [1:0] c_st_serve = 2'd2;

endpackage
`default_nettype wire

// File: rtl/chacha_xor_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : chacha_xor_stream_if
// Brief    : Keystream burst, plaintext and ciphertext stream signals.
// Revision : 1.0
// ============================================================================
interface chacha_xor_stream_if;

  logic                         ks_ready;
  logic                         ks_rd;
  chacha_xor_stream_pkg::byte_t ks_data;
  logic                         in_valid;
  logic                         in_ready;
  chacha_xor_stream_pkg::byte_t in_data;
  logic                         out_valid;
  logic                         out_ready;
  chacha_xor_stream_pkg::byte_t out_data;
  logic                         flush;
  logic [15:0]                  blk_count;

  modport slave (
    input  ks_ready, ks_data, in_valid, in_data, out_ready, flush,
    output ks_rd, in_ready, out_valid, out_data, blk_count
  );

  modport master (
    output ks_ready, ks_data, in_valid, in_data, out_ready, flush,
    input  ks_rd, in_ready, out_valid, out_data, blk_count
  );

endinterface
`default_nettype wire

// File: rtl/chacha_xor_stream_ks_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ks_buffer
// Brief    : One keystream block; synchronous write, asynchronous read.
// Revision : 1.0
// ============================================================================
module ks_buffer
  import chacha_xor_stream_pkg::*;
#(
  parameter int BLOCK_BYTES = c_block_bytes,
  parameter int PTR_W       = c_ptr_w
) (
  input  wire logic             clk,
  input  wire logic             wr_en,
  input  wire logic [PTR_W-1:0] wr_ptr,
  input  wire byte_t            wr_data,
  input  wire logic [PTR_W-1:0] rd_ptr,
  output      byte_t            rd_data
);

  byte_t r_mem [BLOCK_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/chacha_xor_stream.sv
`default_nettype none
// ============================================================================
// Module   : chacha_xor_stream
// Brief    : Captures one keystream burst, then XORs it onto a byte stream.
// Revision : 1.0
// ============================================================================
module chacha_xor_stream
  import chacha_xor_stream_pkg::*;
#(
  parameter int BLOCK_BYTES = c_block_bytes,
  parameter int PTR_W       = c_ptr_w
) (
  input wire logic         clk,
  input wire logic         rst_n,
  chacha_xor_stream_if.slave bus
);

  localparam logic [PTR_W-1:0] c_last = PTR_W'(BLOCK_BYTES - 1);

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_flush_seen;
  logic             r_out_valid;
  byte_t            r_out_data;
  logic [15:0]      r_blk_count;

  logic             w_ks_rd;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_wr_en;
  byte_t            w_ks_byte;

  // Burst byte 0 arrives in the same cycle as the read pulse, so it is combinational.
  assign w_ks_rd    = rst_n && (r_state == c_st_wait) && bus.ks_ready && !bus.flush;
  assign w_in_ready = rst_n && (r_state == c_st_serve) && !bus.flush &&
                      (!r_out_valid || bus.out_ready);
  assign w_accept   = w_in_ready && bus.in_valid;
  assign w_wr_en    = w_ks_rd || (r_state == c_st_fill);

  ks_buffer #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .PTR_W       (PTR_W)
  ) u_ks_buffer (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_ptr  (r_wr_ptr),
    .wr_data (bus.ks_data),
    .rd_ptr  (r_rd_ptr),
    .rd_data (w_ks_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_st_wait;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_flush_seen <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_blk_count  <= '0;
    end else begin
      case (r_state)
        c_st_wait: begin
          if (w_ks_rd) begin
            r_wr_ptr     <= PTR_W'(1);
            r_flush_seen <= 1'b0;
            r_state      <= c_st_fill;
          end
        end
        c_st_fill: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (bus.flush) r_flush_seen <= 1'b1;
          if (r_wr_ptr == c_last) begin
            r_blk_count <= r_blk_count + 16'd1;
            r_rd_ptr    <= '0;
            // A flushed block is still counted but never served.
            r_state     <= (r_flush_seen || bus.flush) ? c_st_wait : c_st_serve;
          end
        end
        c_st_serve: begin
          if (bus.flush) begin
            r_rd_ptr <= '0;
            r_state  <= c_st_wait;
          end else if (w_accept) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_rd_ptr == c_last) r_state <= c_st_wait;
          end
        end
        default: r_state <= c_st_wait;
      endcase

      // The output register is independent of the FSM so a pending byte survives flush.
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.in_data ^ w_ks_byte;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.ks_rd     = w_ks_rd;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.blk_count = r_blk_count;

endmodule
`default_nettype wire

// File: tb/tb_chacha_xor_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_chacha_xor_stream
// Brief    : Core model plus scoreboard bench for chacha_xor_stream.
// Revision : 1.0
// ============================================================================
module tb_chacha_xor_stream;
  import chacha_xor_stream_pkg::*;

  typedef struct {
    byte_t pt;
    byte_t ct;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chacha_xor_stream_if bus ();

  chacha_xor_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_pass     = 0;
  int    n_total    = 0;
  int    ks_rd_cnt  = 0;
  byte_t sb[$];
  byte_t exp_b;
  vec_t  vecs[64];

  // Keystream core model: block n byte i = 0xA0 + 0x20*n + i.
  logic       r_rd_q       = 1'b0;
  logic       r_core_ready = 1'b0;
  logic       r_core_busy  = 1'b0;
  logic [5:0] r_core_idx   = '0;
  logic [7:0] r_core_blk   = '0;
  int         r_core_dly   = 3;

  assign bus.ks_ready = r_core_ready;
  assign bus.ks_data  = 8'hA0 + {r_core_blk[2:0], 5'b0} + {2'b0, r_core_idx};

  always @(posedge clk) begin
    if (!rst_n) begin
      r_core_ready <= 1'b0;
      r_core_busy  <= 1'b0;
      r_core_idx   <= '0;
      r_core_blk   <= '0;
      r_core_dly   <= 3;
    end else if (r_core_busy) begin
      if (r_core_idx == 6'd63) begin
        r_core_busy <= 1'b0;
        r_core_idx  <= '0;
        r_core_blk  <= r_core_blk + 8'd1;
        r_core_dly  <= 3;
      end else begin
        r_core_idx <= r_core_idx + 6'd1;
      end
    end else if (r_core_ready) begin
      if (r_rd_q) begin
        r_core_ready <= 1'b0;
        r_core_busy  <= 1'b1;
        r_core_idx   <= 6'd1;
      end
    end else if (r_core_dly > 0) begin
      r_core_dly <= r_core_dly - 1;
    end else begin
      r_core_ready <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    r_rd_q = bus.ks_rd;
    if (rst_n && bus.ks_rd) ks_rd_cnt++;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("ct_unexpected", 32'd0, 32'd1);
      end else begin
        exp_b = sb.pop_front();
        check("ct", {24'd0, bus.out_data}, {24'd0, exp_b});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input byte_t d, input byte_t exp);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(exp);
        tick();
        break;
      end
      waited++;
      if (waited > 400) begin
        check("send_timeout", 32'd0, 32'd1);
        tick();
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic wait_ks_rd();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.ks_rd) break;
      n++;
      if (n > 200) begin
        check("ks_rd_timeout", 32'd0, 32'd1);
        break;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n     = 1'b1;
    ks_rd_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    logic rdy_at_rd;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    for (int i = 0; i < 64; i++) begin
      vecs[i].pt = 8'(i);
      vecs[i].ct = (8'hA0 + 8'(i)) ^ 8'(i);
    end

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ks_rd",     {31'd0, bus.ks_rd},     32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, bus.out_data},  32'd0);
    check("rst_blk_count", {16'd0, bus.blk_count}, 32'd0);
    rst_n     = 1'b1;
    ks_rd_cnt = 0;

    // Basic block from the vector table
    for (int i = 0; i < 64; i++) send(vecs[i].pt, vecs[i].ct);
    check("blk1_ks_rd_pulses", ks_rd_cnt, 32'd1);
    check("blk1_wait_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("blk1_blk_count", {16'd0, bus.blk_count}, 32'd1);

    // Second block continues the same message
    for (int i = 64; i < 100; i++) send(8'(i), (8'hC0 + 8'(i - 64)) ^ 8'(i));
    drain();
    check("blk2_ks_rd_pulses", ks_rd_cnt, 32'd2);
    check("blk2_blk_count", {16'd0, bus.blk_count}, 32'd2);

    // Backpressure after the first accept
    do_reset();
    bus.out_ready = 1'b0;
    send(8'h00, 8'hA0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_out_data",  {24'd0, bus.out_data},  32'hA0);
      tick();
    end
    bus.out_ready = 1'b1;
    send(8'h01, 8'hA1 ^ 8'h01);
    send(8'h02, 8'hA2 ^ 8'h02);
    drain();

    // Flush while serving
    do_reset();
    for (int i = 0; i < 10; i++) send(8'(i), (8'hA0 + 8'(i)) ^ 8'(i));
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    @(negedge clk);
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 10; i < 20; i++) send(8'(i), (8'hC0 + 8'(i - 10)) ^ 8'(i));
    drain();
    check("flush_ks_rd_pulses", ks_rd_cnt, 32'd2);
    check("flush_blk_count", {16'd0, bus.blk_count}, 32'd2);

    // Flush during FILL discards that block
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_ks_rd();
    repeat (5) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    send(8'h55, 8'h55);
    check("fillflush_blk_count", {16'd0, bus.blk_count}, 32'd4);
    check("fillflush_ks_rd_pulses", ks_rd_cnt, 32'd4);
    drain();

    // Reset during FILL at burst cycle 20
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_ks_rd();
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_ks_rd",     {31'd0, bus.ks_rd},     32'd0);
    check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_out_data",  {24'd0, bus.out_data},  32'd0);
    check("midrst_blk_count", {16'd0, bus.blk_count}, 32'd0);
    rst_n     = 1'b1;
    ks_rd_cnt = 0;
    seen      = 1'b0;
    rdy_at_rd = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (bus.ks_rd) begin
        seen      = 1'b1;
        rdy_at_rd = bus.ks_ready;
      end
      tick();
    end
    check("midrst_ks_rd_seen", {31'd0, seen}, 32'd1);
    check("midrst_ks_rd_ready", {31'd0, rdy_at_rd}, 32'd1);
    send(8'h0F, 8'hA0 ^ 8'h0F);
    drain();
    check("midrst_blk_count_after", {16'd0, bus.blk_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
